// File: rtl/tt_um_serial_addsub_if.sv
// Tile-side bundle for the serial adder/subtractor: the Tiny Tapeout user
// pins grouped together so a driver can hold one handle to the whole tile.
//
// Handshake: an operand bit pair on ui_in[1:0] counts only on a rising clk
// edge where ui_in[4] (bit_valid) is 1 and the tile is in RUN; the tile never
// stalls, so there is no ready. Each accepted pair yields one sum bit on
// uo_out[0] qualified by uo_out[1] (sum_valid) exactly one cycle later.
interface tt_um_serial_addsub_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Master drives the tile inputs (testbench or host logic).
  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  // Slave is the tile itself.
  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_serial_addsub.sv
// Bit-serial two's-complement adder/subtractor tile. Operands arrive LSB
// first; a single carry/borrow flop is reused for every bit. Subtraction is
// A + ~B + 1, with the +1 preloaded into the carry flop at start.
module tt_um_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

  // Input field decode.
  logic a_bit, b_bit, start, sub_in, bit_valid;
  assign a_bit     = ui_in[0];
  assign b_bit     = ui_in[1];
  assign start     = ui_in[2];
  assign sub_in    = ui_in[3];
  assign bit_valid = ui_in[4];

  // ena, uio_in and ui_in[7:5] carry no function in this tile.
  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5]};

  state_e             state_q, state_d;
  logic               sub_q, sub_d;
  logic               carry_q, carry_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               sum_bit_q, sum_bit_d;
  logic               sum_valid_q, sum_valid_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // One full-adder slice shared across all bit positions.
  logic b_eff, sum_s, carry_nx;
  assign b_eff    = b_bit ^ sub_q;
  assign sum_s    = a_bit ^ b_eff ^ carry_q;
  assign carry_nx = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

  // Next-state and datapath updates; everything holds unless a case moves it.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    sum_bit_d   = sum_bit_q;
    sum_valid_d = 1'b0;
    done_d      = done_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start directly so ops can run back to back.
        if (start) begin
          state_d  = S_RUN;
          sub_d    = sub_in;
          carry_d  = sub_in;
          cnt_d    = '0;
          result_d = '0;
          done_d   = 1'b0;
        end
      end
      S_RUN: begin
        // start is deliberately ignored here; gaps simply hold all state.
        if (bit_valid) begin
          carry_d            = carry_nx;
          sum_bit_d          = sum_s;
          sum_valid_d        = 1'b1;
          result_d           = result_q >> 1;
          result_d[WIDTH-1]  = sum_s;
          cnt_d              = cnt_q + 3'd1;
          if (cnt_q == LAST_BIT) begin
            state_d = S_DONE;
            cout_d  = carry_nx;
            // Signed overflow: carry into the MSB differs from carry out.
            ovf_d   = carry_q ^ carry_nx;
            done_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      sum_bit_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      sum_bit_q   <= sum_bit_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  // Output packing; state code on [7:6] doubles as the debug view of the FSM.
  always_comb begin
    uo_out    = {state_q, ovf_q, cout_q, done_q, (state_q == S_RUN),
                 sum_valid_q, sum_bit_q};
    uio_out   = '0;
    uio_out[WIDTH-1:0] = result_q;
    uio_oe    = 8'hFF;
  end

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// Directed testbench for the serial adder/subtractor tile.
module tb_tt_um_serial_addsub;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

  tt_um_serial_addsub_if bus ();

  tt_um_serial_addsub #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uo_out  (bus.uo_out),
    .uio_in  (bus.uio_in),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  // Clock block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive ui_in fields: {bit_valid, sub, start, b, a}.
  task automatic drive(input logic bv, input logic sub, input logic st,
                       input logic b, input logic a);
    bus.ui_in = {3'b000, bv, sub, st, b, a};
  endtask

  // Full operation: start, 8 bits with optional gap before bit gap_at,
  // optional start pulse during the gap, then result checks.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input int gap_at, input int gap_len,
                        input logic start_in_run, input logic [7:0] exp_res,
                        input logic exp_c, input logic exp_v);
    logic [7:0] stream;
    int         sv_count;
    logic       busy_ok;
    stream   = '0;
    sv_count = 0;
    busy_ok  = 1'b1;
    drive(1'b0, sub, 1'b1, 1'b0, 1'b0);
    tick();
    if (bus.uo_out[1]) sv_count++;
    check({tag, "_run_state"}, {30'd0, bus.uo_out[7:6]}, 32'd1);
    check({tag, "_done_clr"}, {31'd0, bus.uo_out[3]}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          drive(1'b0, 1'b0, start_in_run && (g == 1), 1'b0, 1'b0);
          tick();
          if (bus.uo_out[1]) sv_count++;
          if (!bus.uo_out[2]) busy_ok = 1'b0;
        end
      end
      drive(1'b1, 1'b0, 1'b0, b[i], a[i]);
      tick();
      if (bus.uo_out[1]) begin
        sv_count++;
        stream[i] = bus.uo_out[0];
      end
      if (i < 7 && !bus.uo_out[2]) busy_ok = 1'b0;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_done"},   {31'd0, bus.uo_out[3]}, 32'd1);
    check({tag, "_result"}, {24'd0, bus.uio_out},   {24'd0, exp_res});
    check({tag, "_cout"},   {31'd0, bus.uo_out[4]}, {31'd0, exp_c});
    check({tag, "_ovf"},    {31'd0, bus.uo_out[5]}, {31'd0, exp_v});
    check({tag, "_stream"}, {24'd0, stream},        {24'd0, exp_res});
    tick();
    if (bus.uo_out[1]) sv_count++;
    check({tag, "_sv_count"}, sv_count, 32'd8);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_done_state"}, {30'd0, bus.uo_out[7:6]}, 32'd2);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    bus.ena    = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in  = 8'h00;
    rst_n      = 1'b0;
    #12;
    check("por_uo_out",  {24'd0, bus.uo_out},  32'h00);
    check("por_uio_out", {24'd0, bus.uio_out}, 32'h00);
    check("por_uio_oe",  {24'd0, bus.uio_oe},  32'hFF);
    rst_n = 1'b1;
    tick();

    // Plain adds and subtracts.
    run_op("add_35_0a", 8'h35, 8'h0A, 1'b0, -1, 0, 1'b0, 8'h3F, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, -1, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, -1, 0, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, -1, 0, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, -1, 0, 1'b0, 8'h7F, 1'b1, 1'b1);

    // bit_valid in DONE is ignored and the result holds.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("done_bv_sv",    {31'd0, bus.uo_out[1]}, 32'd0);
    check("done_bv_state", {30'd0, bus.uo_out[7:6]}, 32'd2);
    check("done_bv_hold",  {24'd0, bus.uio_out}, 32'h7F);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Gapped input with a start pulse during RUN.
    run_op("gap_35_0a", 8'h35, 8'h0A, 1'b0, 3, 3, 1'b1, 8'h3F, 1'b0, 1'b0);

    // Reset in the middle of an operation, checked before the next edge.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    check("mid_busy", {31'd0, bus.uo_out[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uo_out",  {24'd0, bus.uo_out},  32'h00);
    check("mid_rst_uio_out", {24'd0, bus.uio_out}, 32'h00);
    check("mid_rst_uio_oe",  {24'd0, bus.uio_oe},  32'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Fresh op after the abort, then a back-to-back start from DONE.
    run_op("add_12_34", 8'h12, 8'h34, 1'b0, -1, 0, 1'b0, 8'h46, 1'b0, 1'b0);
    run_op("b2b_10_20", 8'h10, 8'h20, 1'b1, -1, 0, 1'b0, 8'hF0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
